mm_issue_scheduler: RTL and testbench

- Round-robin scheduler that shares one pipelined Montgomery multiplier between NUM_REQ requesters (e.g. square/multiply lanes of several modexp engines).
- Grants one job at a time under a valid/ready handshake and drives the multiplier's en_mm and mm_info_in.
- Routes mm_done results back to the owning requester using the 8-bit info tag.
- Enforces the global in-flight limit, a minimum issue spacing, and at most one outstanding job per requester.

---
 rtl/mm_issue_scheduler_if.sv | 38 +++
 rtl/mm_issue_scheduler.sv | 165 ++++++++++++++++
 tb/tb_mm_issue_scheduler.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_issue_scheduler_if.sv
// Bundle between the issue scheduler and its environment: the requester
// valid/ready side, the Montgomery multiplier issue/completion side, and the
// status outputs. Requesters and the multiplier drive the master side.
interface mm_issue_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 3
);
  // requester side
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*6-1:0] req_tag;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [5:0]           rsp_tag;
  // multiplier side
  logic                 en_mm;
  logic [7:0]           mm_info_in;
  logic [1:0]           mm_opsel;
  logic                 mm_full;
  logic                 mm_done;
  logic [7:0]           mm_info_out;
  // control and status
  logic                 quiesce;
  logic                 drained;
  logic [CNT_W-1:0]     inflight;
  logic                 err;

  modport slave (
    input  req_valid, req_tag, mm_full, mm_done, mm_info_out, quiesce,
    output req_ready, rsp_valid, rsp_tag, en_mm, mm_info_in, mm_opsel,
           drained, inflight, err
  );

  modport master (
    output req_valid, req_tag, mm_full, mm_done, mm_info_out, quiesce,
    input  req_ready, rsp_valid, rsp_tag, en_mm, mm_info_in, mm_opsel,
           drained, inflight, err
  );
endinterface

// File: rtl/mm_issue_scheduler.sv
// Round-robin issue scheduler sharing one pipelined Montgomery multiplier
// between NUM_REQ requesters. One job per grant, one outstanding job per
// requester, a global in-flight cap and a minimum spacing between issues.
// Completions are routed back by the requester id carried in the info tag.
module mm_issue_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int ISSUE_GAP    = 3,
  parameter int CNT_W        = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mm_issue_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_INFLIGHT);
  // The IDLE cycle in which the handshake happens and the ISSUE cycle both
  // count toward the spacing, so GAP only has to cover ISSUE_GAP-2 cycles.
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((ISSUE_GAP > 2) ? ISSUE_GAP - 2 : 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic [1:0]         rr_ptr;
  logic [NUM_REQ-1:0] owner_busy;
  logic [CNT_W-1:0]   inflight_q;
  logic               err_q;
  logic               drained_q;
  logic [7:0]         info_q;
  logic [1:0]         opsel_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [5:0]         rsp_tag_q;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         grant_id;
  logic [5:0]         grant_tag;
  logic               can_issue;
  logic               handshake;

  logic [1:0]         done_id;
  logic               done_busy;
  logic               done_ok;
  logic               done_bad;
  logic [NUM_REQ-1:0] done_clr;
  logic               overflow;

  // Round-robin arbitration: first eligible requester at or after rr_ptr.
  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    logic [1:0] idx;
    idx      = '0;
    grant    = '0;
    grant_id = '0;
    eligible = bus.req_valid & ~owner_busy;
    // rst_n keeps req_ready low while reset is held, like every other output.
    can_issue = rst_n && (state == IDLE) && !bus.quiesce && !bus.mm_full &&
                (inflight_q < MAX_CNT);
    // Scan from the farthest slot back to rr_ptr so the nearest one wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = 2'((int'(rr_ptr) + k) % NUM_REQ);
      if (can_issue && eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
    handshake = |(bus.req_valid & grant);
    grant_tag = bus.req_tag[6*grant_id +: 6];
  end

  // Completion decode: accept only tags that match an outstanding job.
  always_comb begin
    done_id   = bus.mm_info_out[7:6];
    done_busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(done_id) == i) done_busy = owner_busy[i];
    end
    done_ok  = bus.mm_done && done_busy && (inflight_q != '0);
    done_bad = bus.mm_done && !done_ok;
    done_clr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      done_clr[i] = done_ok && (int'(done_id) == i);
    end
    overflow = handshake && !done_ok && (inflight_q == MAX_CNT);
  end

  // Issue-spacing FSM: next state and gap counter.
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    unique case (state)
      IDLE:  if (handshake) state_nxt = ISSUE;
      ISSUE: begin
        if (ISSUE_GAP > 2) begin
          state_nxt   = GAP;
          gap_cnt_nxt = GAP_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt <= CNT_W'(1)) state_nxt = IDLE;
        else                      gap_cnt_nxt = gap_cnt - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // Ownership, in-flight count, issue/response registers and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      owner_busy  <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
      drained_q   <= 1'b0;
      info_q      <= '0;
      opsel_q     <= '0;
      rsp_valid_q <= '0;
      rsp_tag_q   <= '0;
    end else begin
      if (handshake) begin
        info_q  <= {grant_id, grant_tag};
        opsel_q <= grant_id;
        rr_ptr  <= (grant_id == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id + 2'd1;
      end
      // A grant and a completion never target the same requester: grants
      // need owner_busy clear, completions need it set.
      owner_busy  <= (owner_busy & ~done_clr) | grant;
      rsp_valid_q <= done_clr;
      if (done_ok) rsp_tag_q <= bus.mm_info_out[5:0];
      if (handshake && !done_ok && !overflow) inflight_q <= inflight_q + CNT_W'(1);
      else if (!handshake && done_ok)         inflight_q <= inflight_q - CNT_W'(1);
      err_q     <= err_q | done_bad | overflow;
      drained_q <= bus.quiesce && (inflight_q == '0) && (state == IDLE);
    end
  end

  assign bus.req_ready  = grant;
  assign bus.en_mm      = (state == ISSUE);
  assign bus.mm_info_in = info_q;
  assign bus.mm_opsel   = opsel_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.drained    = drained_q;
  assign bus.inflight   = inflight_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_mm_issue_scheduler.sv
// Directed bench for mm_issue_scheduler: single job, round robin with prompt
// completions, back-pressure and in-flight limit, simultaneous issue and
// completion, protocol error, quiesce/drain and asynchronous reset.
module tb_mm_issue_scheduler;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  mm_issue_scheduler_if #(.NUM_REQ(4), .CNT_W(3)) bus ();

  mm_issue_scheduler #(
    .NUM_REQ(4), .MAX_INFLIGHT(4), .ISSUE_GAP(3), .CNT_W(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full grant: IDLE (ready) -> ISSUE -> GAP -> back to IDLE.
  // With echo set, the multiplier returns the job during the ISSUE cycle.
  task automatic grant_cycle(input int g, input int info, input bit echo);
    #1;
    check("grant_ready", 32'(bus.req_ready), 1 << g);
    tick();
    check("issue_en",        32'(bus.en_mm),      1);
    check("issue_info",      32'(bus.mm_info_in), info);
    check("issue_opsel",     32'(bus.mm_opsel),   g);
    check("issue_ready_low", 32'(bus.req_ready),  0);
    if (echo) begin
      bus.mm_done     = 1'b1;
      bus.mm_info_out = 8'(info);
    end
    tick();
    check("gap_en",        32'(bus.en_mm),     0);
    check("gap_ready_low", 32'(bus.req_ready), 0);
    if (echo) begin
      bus.mm_done = 1'b0;
      check("echo_rsp", 32'(bus.rsp_valid), 1 << g);
      check("echo_tag", 32'(bus.rsp_tag),   info & 'h3f);
    end
    tick();
    check("idle_en", 32'(bus.en_mm), 0);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.req_valid   = '0;
    bus.req_tag     = {6'h04, 6'h03, 6'h02, 6'h15};
    bus.mm_full     = 1'b0;
    bus.mm_done     = 1'b0;
    bus.mm_info_out = '0;
    bus.quiesce     = 1'b0;

    // reset state
    tick();
    check("rst_ready",    32'(bus.req_ready),  0);
    check("rst_en",       32'(bus.en_mm),      0);
    check("rst_inflight", 32'(bus.inflight),   0);
    check("rst_err",      32'(bus.err),        0);
    check("rst_drained",  32'(bus.drained),    0);
    check("rst_rsp",      32'(bus.rsp_valid),  0);
    check("rst_info",     32'(bus.mm_info_in), 0);
    #2 rst_n = 1'b1;
    tick();

    // single job, tag 0x15 on requester 0
    bus.req_valid = 4'b0001;
    #1 check("single_ready", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = '0;
    check("single_en",       32'(bus.en_mm),      1);
    check("single_info",     32'(bus.mm_info_in), 'h15);
    check("single_inflight", 32'(bus.inflight),   1);
    tick();
    check("single_hold_en",   32'(bus.en_mm),      0);
    check("single_hold_info", 32'(bus.mm_info_in), 'h15);
    bus.mm_done     = 1'b1;
    bus.mm_info_out = 8'h15;
    tick();
    bus.mm_done = 1'b0;
    check("single_rsp",      32'(bus.rsp_valid), 1);
    check("single_rsp_tag",  32'(bus.rsp_tag),   'h15);
    check("single_inflight0",32'(bus.inflight),  0);
    tick();
    check("single_rsp_pulse", 32'(bus.rsp_valid), 0);

    // round robin from rr_ptr=0, all requesters valid, prompt completions
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    bus.req_tag   = {6'h04, 6'h03, 6'h02, 6'h01};
    bus.req_valid = 4'b1111;
    grant_cycle(0, 'h01, 1'b1);
    grant_cycle(1, 'h42, 1'b1);
    grant_cycle(2, 'h83, 1'b1);
    grant_cycle(3, 'hC4, 1'b1);
    grant_cycle(0, 'h01, 1'b1);
    bus.req_valid = '0;

    // back-pressure: mm_full blocks, release resumes at rr_ptr=1
    bus.mm_full   = 1'b1;
    bus.req_valid = 4'b1011;
    #1 check("full_ready", 32'(bus.req_ready), 0);
    tick();
    check("full_en",     32'(bus.en_mm),     0);
    check("full_ready2", 32'(bus.req_ready), 0);
    tick();
    bus.mm_full   = 1'b0;
    bus.req_valid = 4'b1111;
    grant_cycle(1, 'h42, 1'b0);
    grant_cycle(2, 'h83, 1'b0);
    grant_cycle(3, 'hC4, 1'b0);
    grant_cycle(0, 'h01, 1'b0);
    #1;
    check("limit_inflight", 32'(bus.inflight),  4);
    check("limit_ready",    32'(bus.req_ready), 0);
    tick();
    check("limit_en", 32'(bus.en_mm), 0);
    bus.mm_done     = 1'b1;
    bus.mm_info_out = 8'h83;
    #1 check("limit_done_ready", 32'(bus.req_ready), 0);
    tick();
    bus.mm_done = 1'b0;
    check("limit_rsp",      32'(bus.rsp_valid), 4);
    check("limit_rsp_tag",  32'(bus.rsp_tag),   'h03);
    check("limit_inflight3",32'(bus.inflight),  3);
    grant_cycle(2, 'h83, 1'b0);
    bus.req_valid = '0;

    // drain two, then issue and complete in the same cycle
    bus.mm_done     = 1'b1;
    bus.mm_info_out = 8'h01;
    tick();
    bus.mm_info_out = 8'h42;
    check("drain_rsp0", 32'(bus.rsp_valid), 1);
    check("drain_inf3", 32'(bus.inflight),  3);
    tick();
    bus.req_valid   = 4'b0001;
    bus.mm_info_out = 8'h83;
    check("drain_rsp1", 32'(bus.rsp_valid), 2);
    check("drain_inf2", 32'(bus.inflight),  2);
    #1 check("simul_ready", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = '0;
    check("simul_en",       32'(bus.en_mm),      1);
    check("simul_info",     32'(bus.mm_info_in), 'h01);
    check("simul_rsp",      32'(bus.rsp_valid),  4);
    check("simul_rsp_tag",  32'(bus.rsp_tag),    'h03);
    check("simul_inflight", 32'(bus.inflight),   2);
    check("simul_err",      32'(bus.err),        0);

    // protocol error: completion for idle requester 2
    bus.mm_info_out = 8'h80;
    tick();
    bus.mm_done = 1'b0;
    check("proto_err",      32'(bus.err),       1);
    check("proto_inflight", 32'(bus.inflight),  2);
    check("proto_rsp",      32'(bus.rsp_valid), 0);
    tick();
    check("proto_sticky", 32'(bus.err), 1);

    // quiesce with two in flight
    bus.quiesce     = 1'b1;
    bus.req_valid   = 4'b0010;
    bus.mm_done     = 1'b1;
    bus.mm_info_out = 8'hC4;
    #1;
    check("q_ready",   32'(bus.req_ready), 0);
    check("q_drained", 32'(bus.drained),   0);
    tick();
    bus.mm_info_out = 8'h01;
    check("q_rsp3",     32'(bus.rsp_valid), 8);
    check("q_tag3",     32'(bus.rsp_tag),   'h04);
    check("q_inf1",     32'(bus.inflight),  1);
    check("q_drained1", 32'(bus.drained),   0);
    tick();
    bus.mm_done = 1'b0;
    check("q_rsp0",     32'(bus.rsp_valid), 1);
    check("q_tag0",     32'(bus.rsp_tag),   'h01);
    check("q_inf0",     32'(bus.inflight),  0);
    check("q_drained2", 32'(bus.drained),   0);
    tick();
    check("q_drained3", 32'(bus.drained),   1);
    check("q_ready3",   32'(bus.req_ready), 0);
    bus.quiesce = 1'b0;
    #1 check("unq_ready", 32'(bus.req_ready), 2);
    tick();
    bus.req_valid = '0;
    check("unq_en",   32'(bus.en_mm),      1);
    check("unq_info", 32'(bus.mm_info_in), 'h42);
    check("unq_inf",  32'(bus.inflight),   1);
    tick();
    check("midgap_en",  32'(bus.en_mm),    0);
    check("midgap_inf", 32'(bus.inflight), 1);

    // asynchronous reset in the middle of GAP
    rst_n = 1'b0;
    #1;
    check("arst_en",      32'(bus.en_mm),      0);
    check("arst_inf",     32'(bus.inflight),   0);
    check("arst_err",     32'(bus.err),        0);
    check("arst_drained", 32'(bus.drained),    0);
    check("arst_rsp",     32'(bus.rsp_valid),  0);
    check("arst_info",    32'(bus.mm_info_in), 0);
    check("arst_opsel",   32'(bus.mm_opsel),   0);
    check("arst_ready",   32'(bus.req_ready),  0);
    check("arst_tag",     32'(bus.rsp_tag),    0);
    #2 rst_n = 1'b1;
    tick();
    // the forgotten job completes after reset
    bus.mm_done     = 1'b1;
    bus.mm_info_out = 8'h42;
    tick();
    bus.mm_done = 1'b0;
    check("late_err", 32'(bus.err),       1);
    check("late_rsp", 32'(bus.rsp_valid), 0);
    check("late_inf", 32'(bus.inflight),  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
